// File: rtl/dplca_pkg.sv
// dplca_pkg -- shared definitions for the D-PLCA TXOP allocator.
//
// Contents:
//   dplca_state_e : allocator FSM state encodings (also exported on the debug port)
//   plca_cmd_e    : rx_cmd / tx_cmd encodings
//   STATUS_OK/FAIL: plca_status meaning
//   LFSR_TAPS     : Galois feedback taps for the pick-wait LFSR
//   lfsr_next     : one LFSR step
//   draw_wait     : maps an LFSR value onto a pick-wait length in 0..aging_cycles/2
package dplca_pkg;

    typedef enum logic [3:0] {
        ST_DISABLED            = 4'd0,
        ST_WAIT_BEACON         = 4'd1,
        ST_COORDINATOR         = 4'd2,
        ST_REDUCE_NODE_COUNT   = 4'd3,
        ST_LOOPBACK_TX         = 4'd4,
        ST_LOOPBACK_RX         = 4'd5,
        ST_LEARNING            = 4'd6,
        ST_INCREASE_NODE_COUNT = 4'd7,
        ST_PICK_WAIT           = 4'd8,
        ST_PICK_WAIT_INCREMENT = 4'd9,
        ST_FOLLOWER            = 4'd10
    } dplca_state_e;

    typedef enum logic [1:0] {
        CMD_BEACON = 2'b00,
        CMD_COMMIT = 2'b01,
        CMD_NONE   = 2'b10
    } plca_cmd_e;

    localparam logic STATUS_OK   = 1'b1;
    localparam logic STATUS_FAIL = 1'b0;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

    // The mask M covers L's MSB and everything below it, so x spans at most
    // 0..2L+1; folding the upper part back by (L+1) keeps the result in 0..L.
    function automatic logic [15:0] draw_wait(input logic [15:0] lfsr,
                                              input logic [15:0] aging_cycles);
        logic [15:0] lim;
        logic [15:0] mask;
        logic [15:0] x;
        lim  = aging_cycles >> 1;
        mask = lim;
        mask = mask | (mask >> 1);
        mask = mask | (mask >> 2);
        mask = mask | (mask >> 4);
        mask = mask | (mask >> 8);
        x    = lfsr & mask;
        if (x <= lim) begin
            return x;
        end
        return x - (lim + 16'd1);
    endfunction

endpackage

// File: rtl/dplca_claim_scan.sv
// dplca_claim_scan -- combinational scan of the TXOP claim table.
//
// Ports:
//   claim_table_i [N_TXOP] : bit i set = TXOP i claimed
//   max_claim_o   [ID_W]   : highest claimed index, 0 when nothing is claimed
//   pick_free_o   [ID_W]   : lowest unclaimed index in 1..N_TXOP-2,
//                            N_TXOP-2 when all of those are claimed
module dplca_claim_scan
    import dplca_pkg::*;
#(
    parameter  int N_TXOP = 256,
    localparam int ID_W   = $clog2(N_TXOP)
) (
    input  logic [N_TXOP-1:0] claim_table_i,
    output logic [ID_W-1:0]   max_claim_o,
    output logic [ID_W-1:0]   pick_free_o
);

    // Ascending scan: the last hit wins, giving the highest set index.
    always_comb begin
        max_claim_o = '0;
        for (int i = 0; i < N_TXOP; i++) begin
            if (claim_table_i[i]) begin
                max_claim_o = ID_W'(i);
            end
        end
    end

    // Descending scan over 1..N_TXOP-2: the last hit is the lowest free index.
    // Index 0 is the coordinator slot and N_TXOP-1 is never handed out.
    always_comb begin
        pick_free_o = ID_W'(N_TXOP - 2);
        for (int i = N_TXOP - 2; i >= 1; i--) begin
            if (!claim_table_i[i]) begin
                pick_free_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/dplca_txop_alloc.sv
// dplca_txop_alloc -- D-PLCA transmit-opportunity allocator.
//
// Decides between coordinator (local_nodeID 0) and follower role, adapts the
// advertised node count and picks a free TXOP after a random pick-wait.
//
// Optional feature: define DPLCA_NODE_COUNT_ADAPT_EN to enable the
// REDUCE_NODE_COUNT / INCREASE_NODE_COUNT states. Without it the coordinator
// keeps plca_node_count at MIN_NODE_COUNT.
//
// Ports:
//   clk, reset_n                     : clock, async active-low reset
//   plca_reset, dplca_en, plca_en    : sync disable terms (any -> DISABLED)
//   wait_beacon_timer_done,
//   beacon_timeout_timer_done        : external timer done flags
//   coordinator_role_allowed         : node may become coordinator
//   plca_status                      : 1 = OK, 0 = FAIL
//   rx_cmd, tx_cmd [2]               : 00 BEACON, 01 COMMIT, 10 NONE
//   dplca_txop_table_upd,
//   dplca_new_age                    : one-cycle strobes from table aging
//   dplca_txop_id,
//   dplca_txop_node_count [ID_W]     : fields of the last received BEACON
//   txop_claim_table [N_TXOP]        : claimed TXOP bitmap
//   aging_cycles [16]                : aging period in PLCA cycles
//   local_nodeID, plca_node_count    : registered outputs to PLCA control
//   dplca_aging                      : table aging enable
//   wait_beacon_timer_start,
//   beacon_timeout_timer_start       : one-cycle start pulses
//   state [4]                        : current FSM state (debug)
//
// All outputs are registered. Entry actions are applied on the same edge that
// registers the new state, and only when the state actually changes.
module dplca_txop_alloc
    import dplca_pkg::*;
#(
    parameter  int          N_TXOP         = 256,
    parameter  int          MIN_NODE_COUNT = 8,
    parameter  logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int          ID_W           = $clog2(N_TXOP)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              plca_reset,
    input  logic              dplca_en,
    input  logic              plca_en,
    input  logic              wait_beacon_timer_done,
    input  logic              beacon_timeout_timer_done,
    input  logic              coordinator_role_allowed,
    input  logic              plca_status,
    input  logic [1:0]        rx_cmd,
    input  logic [1:0]        tx_cmd,
    input  logic              dplca_txop_table_upd,
    input  logic              dplca_new_age,
    input  logic [ID_W-1:0]   dplca_txop_id,
    input  logic [ID_W-1:0]   dplca_txop_node_count,
    input  logic [N_TXOP-1:0] txop_claim_table,
    input  logic [15:0]       aging_cycles,
    output logic [ID_W-1:0]   local_nodeID,
    output logic [ID_W-1:0]   plca_node_count,
    output logic              dplca_aging,
    output logic              wait_beacon_timer_start,
    output logic              beacon_timeout_timer_start,
    output logic [3:0]        state
);

    dplca_state_e    state_q, state_d;
    logic [ID_W-1:0] local_id_q, local_id_d;
    logic [ID_W-1:0] node_cnt_q, node_cnt_d;
    logic            aging_q, aging_d;
    logic            wbt_start_q, wbt_start_d;
    logic            bto_start_q, bto_start_d;
    logic [15:0]     pw_count_q, pw_count_d;
    logic [15:0]     pw_cycles_q, pw_cycles_d;
    logic [15:0]     lfsr_q, lfsr_d;

    logic [ID_W-1:0] max_claim;
    logic [ID_W-1:0] pick_free;

    dplca_claim_scan #(
        .N_TXOP (N_TXOP)
    ) u_claim_scan (
        .claim_table_i (txop_claim_table),
        .max_claim_o   (max_claim),
        .pick_free_o   (pick_free)
    );

    // Shorthand terms for the transition conditions.
    logic disable_any;
    logic status_ok;
    logic rx_beacon;
    logic tx_beacon;
    logic upd;
    logic claim0;
    logic follower_conflict;

    assign disable_any = plca_reset || !dplca_en || !plca_en;
    assign status_ok   = (plca_status == STATUS_OK);
    assign rx_beacon   = (rx_cmd == CMD_BEACON);
    assign tx_beacon   = (tx_cmd == CMD_BEACON);
    assign upd         = dplca_txop_table_upd;
    assign claim0      = txop_claim_table[0];

    // A follower gives up its TXOP when someone else claims it, when the
    // coordinator's advertised count no longer covers it, or when it sits
    // above every claimed slot after an aging round (room to move down).
    assign follower_conflict =
        txop_claim_table[local_id_q] ||
        ((dplca_txop_id == '0) && (dplca_txop_node_count <= local_id_q)) ||
        (dplca_new_age && (local_id_q > max_claim));

`ifdef DPLCA_NODE_COUNT_ADAPT_EN
    logic [ID_W-1:0] last_idx;
    logic            claim_last;
    logic            adapt_ok;
    logic            cnt_below_max;
    logic            cnt_above_min;
    logic [ID_W:0]   claim_plus2;
    logic [ID_W:0]   reduce_target;

    assign last_idx      = node_cnt_q - ID_W'(1);
    assign claim_last    = txop_claim_table[last_idx];
    assign adapt_ok      = upd && !claim0 && dplca_new_age;
    assign cnt_below_max = (node_cnt_q < ID_W'(N_TXOP - 1));
    assign cnt_above_min = (node_cnt_q > ID_W'(MIN_NODE_COUNT));

    // max(MAX_CLAIM+2, MIN_NODE_COUNT), clamped to N_TXOP-1; one extra bit
    // keeps MAX_CLAIM+2 from wrapping.
    always_comb begin
        claim_plus2 = {1'b0, max_claim} + (ID_W+1)'(2);
        if (claim_plus2 > (ID_W+1)'(N_TXOP - 1)) begin
            reduce_target = (ID_W+1)'(N_TXOP - 1);
        end else if (claim_plus2 < (ID_W+1)'(MIN_NODE_COUNT)) begin
            reduce_target = (ID_W+1)'(MIN_NODE_COUNT);
        end else begin
            reduce_target = claim_plus2;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (disable_any) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_WAIT_BEACON;
                ST_WAIT_BEACON: begin
                    if (status_ok) begin
                        state_d = ST_LEARNING;
                    end else if (wait_beacon_timer_done) begin
                        state_d = coordinator_role_allowed ? ST_COORDINATOR : ST_DISABLED;
                    end
                end
                ST_COORDINATOR: begin
                    if ((upd && claim0) || rx_beacon) begin
                        state_d = ST_LEARNING;
                    end else if (tx_beacon) begin
                        state_d = ST_LOOPBACK_TX;
`ifdef DPLCA_NODE_COUNT_ADAPT_EN
                    end else if (adapt_ok && claim_last && cnt_below_max) begin
                        state_d = ST_INCREASE_NODE_COUNT;
                    end else if (adapt_ok && !claim_last && cnt_above_min) begin
                        state_d = ST_REDUCE_NODE_COUNT;
`endif
                    end
                end
`ifdef DPLCA_NODE_COUNT_ADAPT_EN
                ST_REDUCE_NODE_COUNT,
                ST_INCREASE_NODE_COUNT: begin
                    if (!dplca_new_age) begin
                        state_d = ST_COORDINATOR;
                    end
                end
`endif
                ST_LOOPBACK_TX: begin
                    if (beacon_timeout_timer_done) begin
                        state_d = ST_DISABLED;
                    end else if (rx_beacon) begin
                        state_d = ST_LOOPBACK_RX;
                    end
                end
                ST_LOOPBACK_RX: begin
                    if (!rx_beacon) begin
                        state_d = ST_COORDINATOR;
                    end
                end
                ST_LEARNING: begin
                    if (!status_ok) begin
                        state_d = ST_DISABLED;
                    end else if (upd && dplca_new_age) begin
                        state_d = ST_PICK_WAIT;
                    end
                end
                ST_PICK_WAIT: begin
                    if (!status_ok) begin
                        state_d = ST_DISABLED;
                    end else if (pw_count_q >= pw_cycles_q) begin
                        state_d = ST_FOLLOWER;
                    end else if (rx_beacon) begin
                        state_d = ST_PICK_WAIT_INCREMENT;
                    end
                end
                ST_PICK_WAIT_INCREMENT: begin
                    if (!rx_beacon) begin
                        state_d = ST_PICK_WAIT;
                    end
                end
                ST_FOLLOWER: begin
                    if (!status_ok) begin
                        state_d = ST_DISABLED;
                    end else if (upd && follower_conflict) begin
                        state_d = ST_PICK_WAIT;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    // Entry actions, keyed on the state being entered.
    always_comb begin
        local_id_d  = local_id_q;
        node_cnt_d  = node_cnt_q;
        aging_d     = aging_q;
        wbt_start_d = 1'b0;
        bto_start_d = 1'b0;
        pw_count_d  = pw_count_q;
        pw_cycles_d = pw_cycles_q;
        lfsr_d      = lfsr_next(lfsr_q);
        if (state_d != state_q) begin
            case (state_d)
                ST_DISABLED: begin
                    wbt_start_d = 1'b1;
                    aging_d     = 1'b0;
                end
                ST_WAIT_BEACON: begin
                    local_id_d = ID_W'(N_TXOP - 2);
                    node_cnt_d = ID_W'(MIN_NODE_COUNT);
                end
                ST_COORDINATOR: begin
                    local_id_d = '0;
                    aging_d    = 1'b1;
                end
`ifdef DPLCA_NODE_COUNT_ADAPT_EN
                ST_REDUCE_NODE_COUNT: begin
                    node_cnt_d = reduce_target[ID_W-1:0];
                end
                ST_INCREASE_NODE_COUNT: begin
                    node_cnt_d = node_cnt_q + ID_W'(1);
                end
`endif
                ST_LOOPBACK_TX: begin
                    bto_start_d = 1'b1;
                end
                ST_LEARNING: begin
                    local_id_d  = ID_W'(N_TXOP - 2);
                    aging_d     = 1'b1;
                    pw_cycles_d = draw_wait(lfsr_q, aging_cycles);
                    pw_count_d  = '0;
                end
                ST_PICK_WAIT_INCREMENT: begin
                    if (pw_count_q != 16'hFFFF) begin
                        pw_count_d = pw_count_q + 16'd1;
                    end
                end
                ST_FOLLOWER: begin
                    local_id_d  = pick_free;
                    pw_cycles_d = draw_wait(lfsr_q, aging_cycles);
                    pw_count_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_DISABLED;
            local_id_q  <= ID_W'(N_TXOP - 2);
            node_cnt_q  <= ID_W'(MIN_NODE_COUNT);
            aging_q     <= 1'b0;
            wbt_start_q <= 1'b0;
            bto_start_q <= 1'b0;
            pw_count_q  <= '0;
            pw_cycles_q <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            local_id_q  <= local_id_d;
            node_cnt_q  <= node_cnt_d;
            aging_q     <= aging_d;
            wbt_start_q <= wbt_start_d;
            bto_start_q <= bto_start_d;
            pw_count_q  <= pw_count_d;
            pw_cycles_q <= pw_cycles_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign local_nodeID               = local_id_q;
    assign plca_node_count            = node_cnt_q;
    assign dplca_aging                = aging_q;
    assign wait_beacon_timer_start    = wbt_start_q;
    assign beacon_timeout_timer_start = bto_start_q;
    assign state                      = state_q;

endmodule

// File: tb/tb_dplca_txop_alloc.sv
// tb_dplca_txop_alloc -- bench for dplca_txop_alloc with default parameters.
// Expected output tuples are queued when stimulus is applied and popped one
// clock later when the DUT has registered its response. Node-count expectations
// follow DPLCA_NODE_COUNT_ADAPT_EN.
module tb_dplca_txop_alloc;
    import dplca_pkg::*;

    localparam int N_TXOP = 256;
    localparam int ID_W   = 8;
    localparam int EXP_W  = 23;
`ifdef DPLCA_NODE_COUNT_ADAPT_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              plca_reset, dplca_en, plca_en;
    logic              wait_beacon_timer_done, beacon_timeout_timer_done;
    logic              coordinator_role_allowed, plca_status;
    logic [1:0]        rx_cmd, tx_cmd;
    logic              dplca_txop_table_upd, dplca_new_age;
    logic [ID_W-1:0]   dplca_txop_id, dplca_txop_node_count;
    logic [N_TXOP-1:0] txop_claim_table;
    logic [15:0]       aging_cycles;
    logic [ID_W-1:0]   local_nodeID, plca_node_count;
    logic              dplca_aging, wait_beacon_timer_start, beacon_timeout_timer_start;
    logic [3:0]        state;

    dplca_txop_alloc dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .plca_reset                 (plca_reset),
        .dplca_en                   (dplca_en),
        .plca_en                    (plca_en),
        .wait_beacon_timer_done     (wait_beacon_timer_done),
        .beacon_timeout_timer_done  (beacon_timeout_timer_done),
        .coordinator_role_allowed   (coordinator_role_allowed),
        .plca_status                (plca_status),
        .rx_cmd                     (rx_cmd),
        .tx_cmd                     (tx_cmd),
        .dplca_txop_table_upd       (dplca_txop_table_upd),
        .dplca_new_age              (dplca_new_age),
        .dplca_txop_id              (dplca_txop_id),
        .dplca_txop_node_count      (dplca_txop_node_count),
        .txop_claim_table           (txop_claim_table),
        .aging_cycles               (aging_cycles),
        .local_nodeID               (local_nodeID),
        .plca_node_count            (plca_node_count),
        .dplca_aging                (dplca_aging),
        .wait_beacon_timer_start    (wait_beacon_timer_start),
        .beacon_timeout_timer_start (beacon_timeout_timer_start),
        .state                      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, tracking the DUT's free-running generator.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr <= 16'hACE1;
        end else if (m_lfsr[0]) begin
            m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
        end else begin
            m_lfsr <= m_lfsr >> 1;
        end
    end

    function automatic logic [15:0] ref_draw(input logic [15:0] lf, input logic [15:0] ac);
        logic [15:0] l, m, x;
        l = ac >> 1;
        m = '0;
        for (int b = 0; b < 15; b++) begin
            if (l[b]) m = (16'(1) << (b + 1)) - 16'd1;
        end
        x = lf & m;
        return (x <= l) ? x : (x - (l + 16'd1));
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [3:0] s, input logic [7:0] id, input logic [7:0] cnt,
                              input logic ag, input logic wbs, input logic bts);
        exp_q.push_back({s, id, cnt, ag, wbs, bts});
    endtask

    task automatic compare_out(input string tag);
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check($sformatf("%s.state", tag), 32'(state),                      32'(e[22:19]));
        check($sformatf("%s.id", tag),    32'(local_nodeID),               32'(e[18:11]));
        check($sformatf("%s.cnt", tag),   32'(plca_node_count),            32'(e[10:3]));
        check($sformatf("%s.aging", tag), 32'(dplca_aging),                32'(e[2]));
        check($sformatf("%s.wbs", tag),   32'(wait_beacon_timer_start),    32'(e[1]));
        check($sformatf("%s.bts", tag),   32'(beacon_timeout_timer_start), 32'(e[0]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic [3:0] s, input logic [7:0] id,
                        input logic [7:0] cnt, input logic ag, input logic wbs, input logic bts);
        expect_out(s, id, cnt, ag, wbs, bts);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    logic [3:0]  e_st;
    logic [7:0]  e_cnt;
    logic [15:0] c_wait;
    bit          found;

    initial begin
        reset_n = 1'b0;
        plca_reset = 1'b0; dplca_en = 1'b0; plca_en = 1'b1;
        wait_beacon_timer_done = 1'b0; beacon_timeout_timer_done = 1'b0;
        coordinator_role_allowed = 1'b1; plca_status = STATUS_FAIL;
        rx_cmd = CMD_NONE; tx_cmd = CMD_NONE;
        dplca_txop_table_upd = 1'b0; dplca_new_age = 1'b0;
        dplca_txop_id = 8'd1; dplca_txop_node_count = 8'd0;
        txop_claim_table = '0; aging_cycles = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        expect_out(ST_DISABLED, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);
        compare_out("reset");
        reset_n = 1'b1;

        // Disabled hold, then coordinator start-up.
        step("dis_hold", ST_DISABLED, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);
        dplca_en = 1'b1;
        step("wb_entry", ST_WAIT_BEACON, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);
        step("wb_idle", ST_WAIT_BEACON, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);
        wait_beacon_timer_done = 1'b1;
        step("coord_entry", ST_COORDINATOR, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0);
        wait_beacon_timer_done = 1'b0;

        // Increase with new_age held: a single increment.
        txop_claim_table[7] = 1'b1;
        dplca_txop_table_upd = 1'b1; dplca_new_age = 1'b1;
        e_st  = ADAPT ? ST_INCREASE_NODE_COUNT : ST_COORDINATOR;
        e_cnt = ADAPT ? 8'd9 : 8'd8;
        step("inc_entry", e_st, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b0;
        step("inc_hold1", e_st, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);
        step("inc_hold2", e_st, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);
        dplca_new_age = 1'b0;
        step("inc_exit", ST_COORDINATOR, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);

        // Climb to 20 with slots 1..18 claimed.
        txop_claim_table = '0;
        for (int i = 1; i <= 18; i++) txop_claim_table[i] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            dplca_txop_table_upd = 1'b1; dplca_new_age = 1'b1;
            if (ADAPT) e_cnt = e_cnt + 8'd1;
            step($sformatf("climb%0d", k), e_st, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);
            dplca_txop_table_upd = 1'b0; dplca_new_age = 1'b0;
            step($sformatf("climb%0d_back", k), ST_COORDINATOR, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);
        end

        // Reduce to MAX_CLAIM+2 = 14 (only slot 12 claimed).
        txop_claim_table = '0;
        txop_claim_table[12] = 1'b1;
        dplca_txop_table_upd = 1'b1; dplca_new_age = 1'b1;
        e_st  = ADAPT ? ST_REDUCE_NODE_COUNT : ST_COORDINATOR;
        e_cnt = ADAPT ? 8'd14 : 8'd8;
        step("red14_entry", e_st, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b0;
        step("red14_hold", e_st, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);
        dplca_new_age = 1'b0;
        step("red14_exit", ST_COORDINATOR, 8'd0, e_cnt, 1'b1, 1'b0, 1'b0);

        // Reduce floors at MIN_NODE_COUNT (only slot 3 claimed: max(5,8)).
        txop_claim_table = '0;
        txop_claim_table[3] = 1'b1;
        dplca_txop_table_upd = 1'b1; dplca_new_age = 1'b1;
        step("red8_entry", e_st, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b0; dplca_new_age = 1'b0;
        step("red8_exit", ST_COORDINATOR, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0);

        // Loopback: successful round trip, then a beacon timeout.
        txop_claim_table = '0;
        tx_cmd = CMD_BEACON;
        step("lbtx_entry", ST_LOOPBACK_TX, 8'd0, 8'd8, 1'b1, 1'b0, 1'b1);
        tx_cmd = CMD_NONE;
        step("lbtx_hold", ST_LOOPBACK_TX, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0);
        rx_cmd = CMD_BEACON;
        step("lbrx_entry", ST_LOOPBACK_RX, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0);
        rx_cmd = CMD_NONE;
        step("lbrx_exit", ST_COORDINATOR, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0);
        tx_cmd = CMD_BEACON;
        step("lbtx2_entry", ST_LOOPBACK_TX, 8'd0, 8'd8, 1'b1, 1'b0, 1'b1);
        tx_cmd = CMD_NONE; beacon_timeout_timer_done = 1'b1;
        step("bto_dis", ST_DISABLED, 8'd0, 8'd8, 1'b0, 1'b1, 1'b0);
        beacon_timeout_timer_done = 1'b0; dplca_en = 1'b0;
        step("dis_hold1", ST_DISABLED, 8'd0, 8'd8, 1'b0, 1'b0, 1'b0);
        step("dis_hold2", ST_DISABLED, 8'd0, 8'd8, 1'b0, 1'b0, 1'b0);

        // Follower path with zero pick-wait.
        aging_cycles = 16'd0;
        txop_claim_table = '0;
        for (int i = 0; i <= 4; i++) txop_claim_table[i] = 1'b1;
        dplca_en = 1'b1;
        step("f_wb", ST_WAIT_BEACON, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);
        plca_status = STATUS_OK;
        step("f_learn", ST_LEARNING, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b1; dplca_new_age = 1'b1;
        step("f_pw", ST_PICK_WAIT, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b0; dplca_new_age = 1'b0;
        step("f_fol5", ST_FOLLOWER, 8'd5, 8'd8, 1'b1, 1'b0, 1'b0);
        step("f_fol5_hold", ST_FOLLOWER, 8'd5, 8'd8, 1'b1, 1'b0, 1'b0);
        txop_claim_table[5] = 1'b1; dplca_txop_table_upd = 1'b1;
        step("f_claimed", ST_PICK_WAIT, 8'd5, 8'd8, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b0;
        step("f_fol6", ST_FOLLOWER, 8'd6, 8'd8, 1'b1, 1'b0, 1'b0);
        dplca_txop_id = 8'd0; dplca_txop_node_count = 8'd3; dplca_txop_table_upd = 1'b1;
        step("f_small_cnt", ST_PICK_WAIT, 8'd6, 8'd8, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b0; dplca_txop_id = 8'd1;
        step("f_fol6b", ST_FOLLOWER, 8'd6, 8'd8, 1'b1, 1'b0, 1'b0);
        plca_en = 1'b0;
        step("f_disable", ST_DISABLED, 8'd6, 8'd8, 1'b0, 1'b1, 1'b0);
        plca_en = 1'b1; plca_status = STATUS_FAIL;
        step("f2_wb", ST_WAIT_BEACON, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);

        // Pick-wait drawn from the LFSR: wait for a draw of at least 2.
        aging_cycles = 16'd10;
        found = 1'b0;
        c_wait = '0;
        for (int k = 0; k < 64 && !found; k++) begin
            c_wait = ref_draw(m_lfsr, aging_cycles);
            if (c_wait >= 16'd2) begin
                found = 1'b1;
                plca_status = STATUS_OK;
                step("f2_learn", ST_LEARNING, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);
            end else begin
                step($sformatf("f2_wb_idle%0d", k), ST_WAIT_BEACON, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);
            end
        end
        check("draw_search", 32'(found), 32'd1);
        dplca_txop_table_upd = 1'b1; dplca_new_age = 1'b1;
        step("f2_pw", ST_PICK_WAIT, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);
        dplca_txop_table_upd = 1'b0; dplca_new_age = 1'b0;
        for (int k = 0; k < int'(c_wait) - 1; k++) begin
            rx_cmd = CMD_BEACON;
            step($sformatf("f2_inc%0d", k), ST_PICK_WAIT_INCREMENT, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);
            rx_cmd = CMD_NONE;
            step($sformatf("f2_back%0d", k), ST_PICK_WAIT, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);
        end
        step("f2_pw_short", ST_PICK_WAIT, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);
        rx_cmd = CMD_BEACON;
        step("f2_inc_last", ST_PICK_WAIT_INCREMENT, 8'd254, 8'd8, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while in PICK_WAIT_INCREMENT.
        reset_n = 1'b0;
        #1;
        expect_out(ST_DISABLED, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);
        compare_out("async_rst");
        rx_cmd = CMD_NONE; plca_status = STATUS_FAIL;
        reset_n = 1'b1;
        step("post_rst", ST_WAIT_BEACON, 8'd254, 8'd8, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
